vgachargen_access_ctrl: RTL and testbench
=========================================

# vgachargen_access_ctrl

System-clock-side access controller for the character generator's three writable memories (ch_map, col_map, ch_t_rw). It serialises a single CPU-style request port onto the `sys_*` memory ports of `vgachargen` and returns read data with fixed latency. It also contains a hardware fill engine that clears or paints the whole screen, writing one cell per cycle, and arbitrates it against CPU traffic.

## Interface
Parameters:
- CELL_COUNT, 2400: number of ch_map/col_map cells swept by a fill (80x30).

Ports:
- sys_clk_i  in  1  system clock; all logic on its rising edge.
- sys_rst_i  in  1  reset; synchronous, active-high.
- req_i  in  1  request valid.
- we_i  in  1  1 = write, 0 = read.
- sel_i  in  2  target: 0 ch_map, 1 col_map, 2 ch_t_rw, 3 reserved.
- addr_i  in  ACC_ADDR_WIDTH  word address; each target uses the LSBs.
- wdata_i  in  ACC_DATA_WIDTH  write data; narrower targets use the LSBs.
- ready_o  out  1  request accepted this cycle when req_i && ready_o.
- rvalid_o  out  1  read data valid.
- rdata_o  out  ACC_DATA_WIDTH  read data, zero-extended.
- fill_start_i  in  1  start-fill pulse.
- fill_ch_i  in  CH_MAP_DATA_WIDTH  character code for the fill.
- fill_col_i  in  8  colour byte for the fill ({fg,bg}).
- busy_o  out  1  fill in progress.
- done_o  out  1  one-cycle pulse when a fill completes.
- ch_map_addr_o / ch_map_data_o / ch_map_wen_o  out  CH_MAP_ADDR_WIDTH / CH_MAP_DATA_WIDTH / 1  to `sys_ch_map_*`.
- col_map_addr_o / col_map_data_o / col_map_wen_o  out  COL_MAP_ADDR_WIDTH / 8 / 1  to `sys_col_map_*`.
- ch_t_rw_addr_o / ch_t_rw_data_o / ch_t_rw_wen_o  out  CH_T_ADDR_WIDTH / CH_T_DATA_WIDTH / 1  to `sys_ch_t_rw_*`.
- ch_map_data_i / col_map_data_i / ch_t_rw_data_i  in  matching widths  port-A read data; 1-cycle synchronous BRAM.

## Operation
- Memory-side outputs are combinational from the accepted request or from the fill engine. A wen is asserted only for an accepted write or an active fill cycle.
- Fill FSM states: IDLE, FILL.
  - IDLE -> FILL when fill_start_i=1 is sampled in IDLE. At that edge: latch fill_ch_i and fill_col_i, clear cnt to 0.
  - In FILL, every cycle: ch_map[cnt]=ch_latched, col_map[cnt]=col_latched, both wen=1, then cnt++.
  - FILL -> IDLE on the cycle that writes cnt=CELL_COUNT-1. done_o=1 on the following cycle.
  - busy_o = (state==FILL).
  - fill_start_i while in FILL is ignored, with no restart.
- Arbitration:
  - The fill has absolute priority over ch_map and col_map. During FILL, ready_o=0 when sel_i is 0 or 1.
  - sel_i=2 (ch_t_rw) is always accepted, including during FILL.
  - sel_i=3 is accepted, writes are dropped, and reads return 0.
  - In IDLE, ready_o=1 for all sel.
  - A request in the same cycle as fill_start_i (state IDLE) is accepted and performed before the first fill write.
- Reads:
  - An accepted read drives the target address with wen=0.
  - rvalid_o=1 exactly one cycle later. rdata_o is muxed from the target's data_i using the registered sel.
  - Back-to-back reads give one rvalid per cycle.
- Writes produce no rvalid. Addresses are not range-checked.

## Timing
- Reset values: state=IDLE, cnt=0, busy_o=0, done_o=0, rvalid_o=0, all wen=0, rdata_o=0.
- Read latency is 1 cycle (accept at edge N, rvalid_o high in cycle N+1).
- A fill of CELL_COUNT cells occupies exactly CELL_COUNT cycles. busy_o is high for CELL_COUNT cycles, then done_o pulses once.
- sys_rst_i mid-fill aborts immediately to IDLE with no done_o. Cells already written stay written. A pending rvalid is dropped.
- cnt is $clog2(CELL_COUNT) bits wide. Wrap-around never occurs because the terminal compare is on CELL_COUNT-1.

## Configuration
- VGACHARGEN_ACCESS_CTRL_FILL_EN defined: fill engine present as described.
- Not defined:
  - no FSM or counter is built.
  - fill_start_i, fill_ch_i and fill_col_i are ignored.
  - busy_o=0 and done_o=0 constantly.
  - ready_o=1 always.

## Structure
- Additions to vgachargen_pkg:
  - acc_sel_e enum (ACC_SEL_CH_MAP, ACC_SEL_COL_MAP, ACC_SEL_CH_T_RW, ACC_SEL_RSVD).
  - ACC_ADDR_WIDTH = max of the three address widths.
  - ACC_DATA_WIDTH = max of the three data widths.
  - fill_state_e enum (FILL_IDLE, FILL_ACTIVE).
- Sub-module vgachargen_fill_engine holds the FSM, the counter and the latches, and is instantiated only under the macro.

## Test plan
- Reset then read: write ch_map[5]=0x41, read ch_map[5] -> rvalid_o the next cycle, rdata_o=0x41.
- Back-to-back: write col_map[0..3]=0x10..0x13, then 4 consecutive reads -> 4 consecutive rvalid cycles returning 0x10,0x11,0x12,0x13.
- Fill: fill_start_i with ch=0x20, col=0x0F -> busy_o high 2400 cycles, done_o a single pulse. Spot-read cells 0, 1199 and 2399 -> 0x20 / 0x0F.
- Contention: during FILL, a ch_map read has ready_o=0 until busy_o falls. A ch_t_rw write to addr 3 in the same window is accepted and reads back correctly.
- Reset mid-fill: assert sys_rst_i after 100 fill cycles -> busy_o=0 and no done_o. Cell 50 holds the fill value; cell 200 holds its prior value.
- Macro off: fill_start_i pulsed -> busy_o and done_o stay 0, and ch_map[0] is unchanged.

Source files
------------

// File: rtl/vgachargen_pkg.sv
// vgachargen_pkg: shared memory widths, access-port widths and the enums used by the access controller
package vgachargen_pkg;
  localparam int CH_MAP_ADDR_WIDTH = 12;
  localparam int CH_MAP_DATA_WIDTH = 7;
  localparam int COL_MAP_ADDR_WIDTH = 12;
  localparam int CH_T_ADDR_WIDTH = 11;
  localparam int CH_T_DATA_WIDTH = 8;
  function automatic int max3(input int a, input int b, input int c);
    return a > b ? (a > c ? a : c) : (b > c ? b : c);
  endfunction
  localparam int ACC_ADDR_WIDTH = max3(CH_MAP_ADDR_WIDTH, COL_MAP_ADDR_WIDTH, CH_T_ADDR_WIDTH);
  localparam int ACC_DATA_WIDTH = max3(CH_MAP_DATA_WIDTH, 8, CH_T_DATA_WIDTH);
  typedef enum logic [1:0] {
    ACC_SEL_CH_MAP  = 2'd0,
    ACC_SEL_COL_MAP = 2'd1,
    ACC_SEL_CH_T_RW = 2'd2,
    ACC_SEL_RSVD    = 2'd3
  } acc_sel_e;
  typedef enum logic {
    FILL_IDLE,
    FILL_ACTIVE
  } fill_state_e;
endpackage

// File: rtl/vgachargen_fill_engine.sv
// vgachargen_fill_engine: screen fill FSM, cell counter and latched fill values
// Only instantiated when VGACHARGEN_ACCESS_CTRL_FILL_EN is defined.
module vgachargen_fill_engine
  import vgachargen_pkg::*;
#(
  parameter int CELL_COUNT = 2400
) (
  input  logic                         sys_clk_i,
  input  logic                         sys_rst_i,
  input  logic                         start_i,
  input  logic [CH_MAP_DATA_WIDTH-1:0] ch_i,
  input  logic [7:0]                   col_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [CH_MAP_ADDR_WIDTH-1:0] addr_o,
  output logic [CH_MAP_DATA_WIDTH-1:0] ch_o,
  output logic [7:0]                   col_o
);
  localparam int CW = $clog2(CELL_COUNT);
  fill_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CH_MAP_DATA_WIDTH-1:0] ch_q, ch_d;
  logic [7:0] col_q, col_d;
  logic done_q, done_d;
  logic last;
  assign last = cnt_q == CW'(CELL_COUNT - 1);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    ch_d = ch_q;
    col_d = col_q;
    done_d = 1'b0;
    if (state_q == FILL_IDLE) begin
      if (start_i) begin
        state_d = FILL_ACTIVE;
        cnt_d = '0;
        ch_d = ch_i;
        col_d = col_i;
      end
    end else begin
      state_d = last ? FILL_IDLE : FILL_ACTIVE;
      cnt_d = last ? '0 : cnt_q + 1'b1;
      done_d = last;
    end
  end
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state_q <= FILL_IDLE;
      cnt_q <= '0;
      ch_q <= '0;
      col_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ch_q <= ch_d;
      col_q <= col_d;
      done_q <= done_d;
    end
  end
  assign busy_o = state_q == FILL_ACTIVE;
  assign done_o = done_q;
  assign addr_o = CH_MAP_ADDR_WIDTH'(cnt_q);
  assign ch_o = ch_q;
  assign col_o = col_q;
endmodule

// File: rtl/vgachargen_access_ctrl.sv
// vgachargen_access_ctrl: serialises CPU requests onto the vgachargen sys_* memory ports
// Optional screen fill engine enabled by VGACHARGEN_ACCESS_CTRL_FILL_EN.
module vgachargen_access_ctrl
  import vgachargen_pkg::*;
#(
  parameter int CELL_COUNT = 2400
) (
  input  logic                          sys_clk_i,
  input  logic                          sys_rst_i,
  input  logic                          req_i,
  input  logic                          we_i,
  input  logic [1:0]                    sel_i,
  input  logic [ACC_ADDR_WIDTH-1:0]     addr_i,
  input  logic [ACC_DATA_WIDTH-1:0]     wdata_i,
  output logic                          ready_o,
  output logic                          rvalid_o,
  output logic [ACC_DATA_WIDTH-1:0]     rdata_o,
  input  logic                          fill_start_i,
  input  logic [CH_MAP_DATA_WIDTH-1:0]  fill_ch_i,
  input  logic [7:0]                    fill_col_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic [CH_MAP_ADDR_WIDTH-1:0]  ch_map_addr_o,
  output logic [CH_MAP_DATA_WIDTH-1:0]  ch_map_data_o,
  output logic                          ch_map_wen_o,
  output logic [COL_MAP_ADDR_WIDTH-1:0] col_map_addr_o,
  output logic [7:0]                    col_map_data_o,
  output logic                          col_map_wen_o,
  output logic [CH_T_ADDR_WIDTH-1:0]    ch_t_rw_addr_o,
  output logic [CH_T_DATA_WIDTH-1:0]    ch_t_rw_data_o,
  output logic                          ch_t_rw_wen_o,
  input  logic [CH_MAP_DATA_WIDTH-1:0]  ch_map_data_i,
  input  logic [7:0]                    col_map_data_i,
  input  logic [CH_T_DATA_WIDTH-1:0]    ch_t_rw_data_i
);
  logic busy, done;
  logic [CH_MAP_ADDR_WIDTH-1:0] fill_addr;
  logic [CH_MAP_DATA_WIDTH-1:0] fill_ch;
  logic [7:0] fill_col;
`ifdef VGACHARGEN_ACCESS_CTRL_FILL_EN
  vgachargen_fill_engine #(.CELL_COUNT(CELL_COUNT)) u_fill (
    .sys_clk_i(sys_clk_i),
    .sys_rst_i(sys_rst_i),
    .start_i(fill_start_i),
    .ch_i(fill_ch_i),
    .col_i(fill_col_i),
    .busy_o(busy),
    .done_o(done),
    .addr_o(fill_addr),
    .ch_o(fill_ch),
    .col_o(fill_col)
  );
`else
  logic unused_fill;
  assign unused_fill = ^{fill_start_i, fill_ch_i, fill_col_i};
  assign busy = 1'b0;
  assign done = 1'b0;
  assign fill_addr = '0;
  assign fill_ch = '0;
  assign fill_col = '0;
`endif
  acc_sel_e sel, sel_q, sel_d;
  logic rvalid_q, rvalid_d;
  logic acc, wr;
  logic [ACC_DATA_WIDTH-1:0] rd_mux;
  assign sel = acc_sel_e'(sel_i);
  // The fill owns both screen maps while active; ch_t_rw and reserved stay open.
  assign ready_o = !(busy && (sel == ACC_SEL_CH_MAP || sel == ACC_SEL_COL_MAP));
  assign acc = req_i && ready_o;
  assign wr = acc && we_i;
  assign busy_o = busy;
  assign done_o = done;
  assign ch_map_addr_o = busy ? fill_addr : addr_i[CH_MAP_ADDR_WIDTH-1:0];
  assign ch_map_data_o = busy ? fill_ch : wdata_i[CH_MAP_DATA_WIDTH-1:0];
  assign ch_map_wen_o = busy || (wr && sel == ACC_SEL_CH_MAP);
  assign col_map_addr_o = busy ? COL_MAP_ADDR_WIDTH'(fill_addr) : addr_i[COL_MAP_ADDR_WIDTH-1:0];
  assign col_map_data_o = busy ? fill_col : wdata_i[7:0];
  assign col_map_wen_o = busy || (wr && sel == ACC_SEL_COL_MAP);
  assign ch_t_rw_addr_o = addr_i[CH_T_ADDR_WIDTH-1:0];
  assign ch_t_rw_data_o = wdata_i[CH_T_DATA_WIDTH-1:0];
  assign ch_t_rw_wen_o = wr && sel == ACC_SEL_CH_T_RW;
  always_comb begin
    rvalid_d = acc && !we_i;
    sel_d = acc ? sel : sel_q;
    rd_mux = sel_q == ACC_SEL_CH_MAP  ? ACC_DATA_WIDTH'(ch_map_data_i) :
             sel_q == ACC_SEL_COL_MAP ? ACC_DATA_WIDTH'(col_map_data_i) :
             sel_q == ACC_SEL_CH_T_RW ? ACC_DATA_WIDTH'(ch_t_rw_data_i) : '0;
  end
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      rvalid_q <= 1'b0;
      sel_q <= ACC_SEL_CH_MAP;
    end else begin
      rvalid_q <= rvalid_d;
      sel_q <= sel_d;
    end
  end
  assign rvalid_o = rvalid_q;
  assign rdata_o = rvalid_q ? rd_mux : '0;
endmodule

// File: tb/tb_vgachargen_access_ctrl.sv
// tb_vgachargen_access_ctrl: scoreboard bench with behavioural BRAMs; fill tests when VGACHARGEN_ACCESS_CTRL_FILL_EN is defined
module tb_vgachargen_access_ctrl;
  import vgachargen_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic req = 1'b0, we = 1'b0, fill_start = 1'b0;
  logic [1:0] sel = 2'd0;
  logic [ACC_ADDR_WIDTH-1:0] addr = '0;
  logic [ACC_DATA_WIDTH-1:0] wdata = '0;
  logic [CH_MAP_DATA_WIDTH-1:0] fill_ch = '0;
  logic [7:0] fill_col = '0;
  logic ready_o, rvalid_o, busy_o, done_o;
  logic [ACC_DATA_WIDTH-1:0] rdata_o;
  logic [CH_MAP_ADDR_WIDTH-1:0] ch_map_addr;
  logic [CH_MAP_DATA_WIDTH-1:0] ch_map_data, ch_map_rd;
  logic ch_map_wen;
  logic [COL_MAP_ADDR_WIDTH-1:0] col_map_addr;
  logic [7:0] col_map_data, col_map_rd;
  logic col_map_wen;
  logic [CH_T_ADDR_WIDTH-1:0] ch_t_addr;
  logic [CH_T_DATA_WIDTH-1:0] ch_t_data, ch_t_rd;
  logic ch_t_wen;
  vgachargen_access_ctrl #(.CELL_COUNT(2400)) dut (
    .sys_clk_i(clk), .sys_rst_i(rst),
    .req_i(req), .we_i(we), .sel_i(sel), .addr_i(addr), .wdata_i(wdata),
    .ready_o(ready_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .fill_start_i(fill_start), .fill_ch_i(fill_ch), .fill_col_i(fill_col),
    .busy_o(busy_o), .done_o(done_o),
    .ch_map_addr_o(ch_map_addr), .ch_map_data_o(ch_map_data), .ch_map_wen_o(ch_map_wen),
    .col_map_addr_o(col_map_addr), .col_map_data_o(col_map_data), .col_map_wen_o(col_map_wen),
    .ch_t_rw_addr_o(ch_t_addr), .ch_t_rw_data_o(ch_t_data), .ch_t_rw_wen_o(ch_t_wen),
    .ch_map_data_i(ch_map_rd), .col_map_data_i(col_map_rd), .ch_t_rw_data_i(ch_t_rd)
  );
  logic [CH_MAP_DATA_WIDTH-1:0] ch_mem [1 << CH_MAP_ADDR_WIDTH];
  logic [7:0] col_mem [1 << COL_MAP_ADDR_WIDTH];
  logic [CH_T_DATA_WIDTH-1:0] ch_t_mem [1 << CH_T_ADDR_WIDTH];
  always @(posedge clk) begin
    if (ch_map_wen) ch_mem[ch_map_addr] <= ch_map_data;
    if (col_map_wen) col_mem[col_map_addr] <= col_map_data;
    if (ch_t_wen) ch_t_mem[ch_t_addr] <= ch_t_data;
    ch_map_rd <= ch_mem[ch_map_addr];
    col_map_rd <= col_mem[col_map_addr];
    ch_t_rd <= ch_t_mem[ch_t_addr];
  end
  int tests = 0, fails = 0;
  int streak = 0, max_streak = 0, busy_cnt = 0, done_cnt = 0;
  logic [7:0] exp_q[$];
  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rvalid_o) begin
      streak <= streak + 1;
      max_streak <= streak + 1 > max_streak ? streak + 1 : max_streak;
      if (exp_q.size() == 0) check("unexpected_rvalid", int'(rdata_o), -1);
      else check("rdata", int'(rdata_o), int'(exp_q.pop_front()));
    end else begin
      streak <= 0;
    end
    if (busy_o) busy_cnt <= busy_cnt + 1;
    if (done_o) done_cnt <= done_cnt + 1;
  end
  task automatic xfer(input logic w, input logic [1:0] s, input int a, input int d, input int e, output int waited);
    waited = 0;
    @(negedge clk);
    req = 1'b1; we = w; sel = s; addr = ACC_ADDR_WIDTH'(a); wdata = ACC_DATA_WIDTH'(d);
    #1;
    while (!ready_o && waited < 5000) begin
      @(negedge clk);
      #1;
      waited++;
    end
    check("ready_accept", int'(ready_o), 1);
    if (ready_o && !w) exp_q.push_back(8'(e));
    @(negedge clk);
    req = 1'b0; we = 1'b0;
  endtask
  task automatic wr(input logic [1:0] s, input int a, input int d);
    int w;
    xfer(1'b1, s, a, d, 0, w);
  endtask
  task automatic rd(input logic [1:0] s, input int a, input int e);
    int w;
    xfer(1'b0, s, a, 0, e, w);
  endtask
  task automatic pulse_fill(input int c, input int k);
    @(negedge clk);
    fill_start = 1'b1; fill_ch = CH_MAP_DATA_WIDTH'(c); fill_col = 8'(k);
    @(negedge clk);
    fill_start = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
  initial begin
    int w, b0, d0;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy_o), 0);
    check("rst_done", int'(done_o), 0);
    check("rst_rvalid", int'(rvalid_o), 0);
    check("rst_rdata", int'(rdata_o), 0);
    check("rst_wen", int'({ch_map_wen, col_map_wen, ch_t_wen}), 0);
    check("rst_ready", int'(ready_o), 1);
    rst = 1'b0;
    wr(2'd0, 5, 'h41);
    rd(2'd0, 5, 'h41);
    for (int i = 0; i < 4; i++) wr(2'd1, i, 'h10 + i);
    @(negedge clk);
    req = 1'b1; we = 1'b0; sel = 2'd1;
    for (int i = 0; i < 4; i++) begin
      addr = ACC_ADDR_WIDTH'(i);
      #1;
      check("b2b_ready", int'(ready_o), 1);
      exp_q.push_back(8'('h10 + i));
      @(negedge clk);
    end
    req = 1'b0;
    repeat (3) @(negedge clk);
    check("b2b_streak", max_streak, 4);
    wr(2'd3, 9, 'hEE);
    rd(2'd3, 9, 0);
    wr(2'd2, 100, 'hC3);
    rd(2'd2, 100, 'hC3);
`ifdef VGACHARGEN_ACCESS_CTRL_FILL_EN
    wr(2'd0, 200, 'h55);
    wr(2'd1, 200, 'h66);
    d0 = done_cnt;
    pulse_fill('h2A, 'hA5);
    repeat (99) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", int'(busy_o), 0);
    repeat (5) @(negedge clk);
    check("midrst_no_done", done_cnt - d0, 0);
    rd(2'd0, 50, 'h2A);
    rd(2'd1, 50, 'hA5);
    rd(2'd0, 200, 'h55);
    rd(2'd1, 200, 'h66);
    b0 = busy_cnt;
    d0 = done_cnt;
    pulse_fill('h20, 'h0F);
    check("fill_busy", int'(busy_o), 1);
    xfer(1'b1, 2'd2, 3, 'h5A, 0, w);
    check("cht_wr_wait", w, 0);
    xfer(1'b0, 2'd2, 3, 0, 'h5A, w);
    check("cht_rd_wait", w, 0);
    pulse_fill('h33, 'h77);
    xfer(1'b0, 2'd0, 0, 0, 'h20, w);
    check("chmap_stalled", int'(w > 2000), 1);
    check("chmap_after_busy", int'(busy_o), 0);
    repeat (3) @(negedge clk);
    check("busy_cycles", busy_cnt - b0, 2400);
    check("done_pulses", done_cnt - d0, 1);
    rd(2'd1, 0, 'h0F);
    rd(2'd0, 1199, 'h20);
    rd(2'd1, 1199, 'h0F);
    rd(2'd0, 2399, 'h20);
    rd(2'd1, 2399, 'h0F);
    rd(2'd2, 3, 'h5A);
`else
    wr(2'd0, 0, 'h12);
    b0 = busy_cnt;
    d0 = done_cnt;
    pulse_fill('h20, 'h0F);
    sel = 2'd0;
    #1;
    check("off_ready", int'(ready_o), 1);
    repeat (10) @(negedge clk);
    check("off_busy", busy_cnt - b0, 0);
    check("off_done", done_cnt - d0, 0);
    rd(2'd0, 0, 'h12);
`endif
    repeat (3) @(negedge clk);
    check("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
